clock_display_scan: RTL and testbench
=====================================

// Module: clock_display_scan
// PURPOSE
//  Display-side consumer of the 12-hour clock core: reads its BCD hh/mm/ss and pm outputs
//  and drives the 3-digit multiplexed seven-segment display (active-low segments and enables).
//  Three pages (hours+AM/PM, minutes, seconds) are selected by a debounced button pulse.
//  Inputs are snapshotted once per scan frame, so a displayed frame never mixes two clock values.
// PARAMETERS
//  CLK_HZ        12_000_000  system clock frequency in Hz
//  SCAN_HZ       3000        digit-slot rate in Hz; DIV = CLK_HZ/SCAN_HZ clocks per slot (frame = 3 slots)
//  BLANK_CYCLES  16          clocks at the start of each slot with all digits off (anti-ghost); must be < DIV
// PORTS
//  clk        in   1  system clock, single clock domain
//  reset      in   1  asynchronous, active-high reset
//  pm         in   1  1 = PM, from the clock core
//  hh         in   8  BCD hours {tens,ones}, 01..12
//  mm         in   8  BCD minutes 00..59
//  ss         in   8  BCD seconds 00..59
//  page_next  in   1  synchronous, debounced; each rising edge requests the next page
//  seg_n      out  8  {dp,g,f,e,d,c,b,a}, active-low, registered
//  dig_en_n   out  3  digit enables, active-low, bit2 = leftmost digit, registered
//  page       out  2  current page: 0 hours, 1 minutes, 2 seconds
// BEHAVIOUR
//  - Reset (async): seg_n=8'hFF, dig_en_n=3'b111, page=0, slot counter=0, digit idx=0, snapshot=0,
//    pending=0, prime=1.
//  - Slot counter cnt runs 0..DIV-1; at DIV-1 it wraps and idx advances 0->1->2->0 (idx 0 = rightmost digit).
//  - Frame boundary = cycle with cnt==DIV-1 and idx==2. On that cycle: snapshot <= {pm,hh,mm,ss};
//    if pending, page <= (page==2) ? 0 : page+1 and pending <= 0.
//  - prime: on the first clock after reset, snapshot is loaded and prime clears, so frame 0 is valid.
//  - page_next: internal edge detect; a rising edge sets pending; pending saturates (several edges in one
//    frame = one advance). A held level advances once. An edge on the boundary cycle applies at that boundary.
//  - Outputs are registered and reflect (cnt,idx) of the previous cycle, i.e. 1-cycle latency.
//    dig_en_n = 3'b111 while cnt < BLANK_CYCLES, else one-hot-low on idx.
//    seg_n = glyph for (page, idx) from the snapshot; seg_n changes only while the digits are blanked.
//  - Page layout (digit2,digit1,digit0): page0 = 'A'/'P' (from pm), hh tens, hh ones;
//    page1 = '-', mm tens, mm ones; page2 = '_', ss tens, ss ones. dp is always off.
//  - Glyphs (seg_n): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 P=8C '-'=BF '_'=F7 blank=FF.
//    A BCD nibble of 0xA..0xF renders as '-' (BF). No X propagation.
//  - Reset mid-slot: outputs return to reset values immediately (async); the scan restarts at idx 0 with
//    a full blanking period.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: on page 0, an hh tens nibble of 0 renders blank (FF);
//    the minutes and seconds tens digits are never blanked.
//  Not defined: all tens digits render literally (hh=8'h09 shows '0','9').
// TESTING (bench override: CLK_HZ=12, SCAN_HZ=1 -> DIV=12, BLANK_CYCLES=2)
//  1 Assert reset mid-slot -> seg_n=FF, dig_en_n=111, page=0 in the same cycle;
//    after release, digit0 enable (110) appears at cycle 3, then 101 at 15, then 011 at 27.
//  2 pm=1, hh=8'h12, page 0 -> per frame seg_n = 8C(digit2), F9(digit1), A4(digit0);
//    pm=0 -> digit2 = 88.
//  3 Change ss from 8'h59 to 8'h00 mid-frame on page 2 -> current frame still shows 5,9;
//    next frame shows C0,C0; never a mix within a frame.
//  4 page_next held high for 5 frames -> page advances once (0->1) at the next boundary;
//    three pulses within one frame -> single advance; from page 2 a pulse -> page 0.
//  5 hh=8'h07: with LEADING_ZERO_BLANK_EN -> digit1 = FF; without it -> C0.
//    mm=8'h5C -> minutes ones digit = BF.
//  6 During each slot check: dig_en_n==111 for the first 2 cycles; seg_n stable whenever any enable is low.

Source files
------------

// File: rtl/clock_display_scan.sv
// Three-digit multiplexed seven-segment scanner for the 12-hour clock core (hours/minutes/seconds pages).
// Optional LEADING_ZERO_BLANK_EN: blank a zero hours-tens digit on the hours page.
module clock_display_scan #(
   parameter int unsigned CLK_HZ       = 12_000_000,
   parameter int unsigned SCAN_HZ      = 3000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pm,
   input  logic [7:0] hh,
   input  logic [7:0] mm,
   input  logic [7:0] ss,
   input  logic       page_next,
   output logic [7:0] seg_n,
   output logic [2:0] dig_en_n,
   output logic [1:0] page
);

   localparam int unsigned DIV      = CLK_HZ / SCAN_HZ;
   localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   localparam logic [7:0] G_A     = 8'h88;
   localparam logic [7:0] G_P     = 8'h8C;
   localparam logic [7:0] G_DASH  = 8'hBF;
   localparam logic [7:0] G_UNDER = 8'hF7;
   localparam logic [7:0] G_BLANK = 8'hFF;

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          pending;
   logic          prime;
   logic          page_next_q;
   logic          snap_pm;
   logic [7:0]    snap_hh;
   logic [7:0]    snap_mm;
   logic [7:0]    snap_ss;

   logic          rise;
   logic          frame_end;
   logic [7:0]    glyph_c;
   logic [2:0]    en_c;

   // BCD digit to active-low segments; non-decimal nibbles show a dash
   function automatic logic [7:0] bcd_glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0:    g = 8'hC0;
         4'd1:    g = 8'hF9;
         4'd2:    g = 8'hA4;
         4'd3:    g = 8'hB0;
         4'd4:    g = 8'h99;
         4'd5:    g = 8'h92;
         4'd6:    g = 8'h82;
         4'd7:    g = 8'hF8;
         4'd8:    g = 8'h80;
         4'd9:    g = 8'h90;
         default: g = G_DASH;
      endcase
      return g;
   endfunction

   assign rise      = page_next & ~page_next_q;
   assign frame_end = (cnt == CNT_MAX) && (idx == 2'd2);

   // glyph and enable for the slot currently being scanned
   always_comb begin
      glyph_c = G_BLANK;
      en_c    = 3'b111;
      case (page)
         2'd0: begin
            case (idx)
               2'd0: glyph_c = bcd_glyph(snap_hh[3:0]);
               2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                  glyph_c = (snap_hh[7:4] == 4'd0) ? G_BLANK : bcd_glyph(snap_hh[7:4]);
`else
                  glyph_c = bcd_glyph(snap_hh[7:4]);
`endif
               end
               2'd2:    glyph_c = snap_pm ? G_P : G_A;
               default: glyph_c = G_BLANK;
            endcase
         end
         2'd1: begin
            case (idx)
               2'd0:    glyph_c = bcd_glyph(snap_mm[3:0]);
               2'd1:    glyph_c = bcd_glyph(snap_mm[7:4]);
               2'd2:    glyph_c = G_DASH;
               default: glyph_c = G_BLANK;
            endcase
         end
         2'd2: begin
            case (idx)
               2'd0:    glyph_c = bcd_glyph(snap_ss[3:0]);
               2'd1:    glyph_c = bcd_glyph(snap_ss[7:4]);
               2'd2:    glyph_c = G_UNDER;
               default: glyph_c = G_BLANK;
            endcase
         end
         default: glyph_c = G_BLANK;
      endcase
      if (cnt >= BLANK_END) begin
         case (idx)
            2'd0:    en_c = 3'b110;
            2'd1:    en_c = 3'b101;
            2'd2:    en_c = 3'b011;
            default: en_c = 3'b111;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         idx         <= 2'd0;
         page        <= 2'd0;
         pending     <= 1'b0;
         prime       <= 1'b1;
         page_next_q <= 1'b0;
         snap_pm     <= 1'b0;
         snap_hh     <= 8'h00;
         snap_mm     <= 8'h00;
         snap_ss     <= 8'h00;
         seg_n       <= G_BLANK;
         dig_en_n    <= 3'b111;
      end else begin
         page_next_q <= page_next;
         seg_n       <= glyph_c;
         dig_en_n    <= en_c;

         if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end

         // snapshot only between frames so one frame never mixes two clock values
         if (prime || frame_end) begin
            snap_pm <= pm;
            snap_hh <= hh;
            snap_mm <= mm;
            snap_ss <= ss;
         end
         prime <= 1'b0;

         if (frame_end) begin
            if (pending || rise) begin
               page <= (page == 2'd2) ? 2'd0 : page + 2'd1;
            end
            pending <= 1'b0;
         end else if (rise) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan with DIV=12, BLANK_CYCLES=2.
// Expected glyphs/pages are queued per frame and popped as each slot lights up.
module tb_clock_display_scan;

   logic       clk;
   logic       reset;
   logic       pm;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       page_next;
   logic [7:0] seg_n;
   logic [2:0] dig_en_n;
   logic [1:0] page;

   int total = 0;
   int bad   = 0;

   logic [7:0] seg_q[$];
   logic [1:0] page_q[$];
   logic [1:0] m_page;
   logic       lvl_prev;

   clock_display_scan #(
      .CLK_HZ(12),
      .SCAN_HZ(1),
      .BLANK_CYCLES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pm(pm),
      .hh(hh),
      .mm(mm),
      .ss(ss),
      .page_next(page_next),
      .seg_n(seg_n),
      .dig_en_n(dig_en_n),
      .page(page)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gl(input logic [3:0] d);
      case (d)
         4'h0: return 8'hC0;
         4'h1: return 8'hF9;
         4'h2: return 8'hA4;
         4'h3: return 8'hB0;
         4'h4: return 8'h99;
         4'h5: return 8'h92;
         4'h6: return 8'h82;
         4'h7: return 8'hF8;
         4'h8: return 8'h80;
         4'h9: return 8'h90;
         default: return 8'hBF;
      endcase
   endfunction

   // queue expectations for one frame, in scan order digit0, digit1, digit2
   task automatic push_frame(input logic [1:0] pg, input logic p, input logic [7:0] h,
                             input logic [7:0] m, input logic [7:0] s);
      page_q.push_back(pg);
      case (pg)
         2'd0: begin
            seg_q.push_back(gl(h[3:0]));
`ifdef LEADING_ZERO_BLANK_EN
            seg_q.push_back((h[7:4] == 4'h0) ? 8'hFF : gl(h[7:4]));
`else
            seg_q.push_back(gl(h[7:4]));
`endif
            seg_q.push_back(p ? 8'h8C : 8'h88);
         end
         2'd1: begin
            seg_q.push_back(gl(m[3:0]));
            seg_q.push_back(gl(m[7:4]));
            seg_q.push_back(8'hBF);
         end
         default: begin
            seg_q.push_back(gl(s[3:0]));
            seg_q.push_back(gl(s[7:4]));
            seg_q.push_back(8'hF7);
         end
      endcase
   endtask

   // check the frame on display; inputs change mid-frame, pulses in slot 0, level applied in slot 1
   task automatic run_frame(input logic npm, input logic [7:0] nhh, input logic [7:0] nmm,
                            input logic [7:0] nss, input int npulse, input logic hold);
      logic       lvl;
      logic       rs;
      logic [7:0] held;
      logic [7:0] exp_seg;
      logic [2:0] exp_en;
      lvl = lvl_prev;
      rs  = 1'b0;
      for (int p = 0; p < npulse; p++) begin
         if (!lvl) rs = 1'b1;
         lvl = 1'b0;
      end
      if (hold && !lvl) rs = 1'b1;
      lvl_prev = hold;
      if (rs) m_page = (m_page == 2'd2) ? 2'd0 : m_page + 2'd1;
      push_frame(m_page, npm, nhh, nmm, nss);
      held = 8'hFF;
      for (int s = 0; s < 3; s++) begin
         for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            exp_en = (c < 2) ? 3'b111 : ((s == 0) ? 3'b110 : (s == 1) ? 3'b101 : 3'b011);
            chk("dig_en_n", {5'b0, dig_en_n}, {5'b0, exp_en});
            if (c == 2) begin
               if (seg_q.size() == 0) begin
                  total++;
                  bad++;
                  $error("FAIL seg_queue observed=empty expected=entry");
               end else begin
                  exp_seg = seg_q.pop_front();
                  chk("seg_n", seg_n, exp_seg);
               end
               if (s == 0 && page_q.size() != 0) chk("page", {6'b0, page}, {6'b0, page_q.pop_front()});
               held = seg_n;
            end else if (c > 2) begin
               chk("seg_stable", seg_n, held);
            end
            if (s == 0 && c >= 3 && c <= 2 + 2 * npulse) page_next = ((c - 3) % 2 == 0);
            if (s == 1 && c == 5) begin
               pm = npm;
               hh = nhh;
               mm = nmm;
               ss = nss;
               page_next = hold;
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      pm = 1'b0;
      hh = 8'h00;
      mm = 8'h00;
      ss = 8'h00;
      page_next = 1'b0;
      #22;
      reset = 1'b0;
      repeat (7) @(posedge clk);

      // asynchronous reset mid-slot
      #1;
      reset = 1'b1;
      #1;
      chk("rst_seg_n", seg_n, 8'hFF);
      chk("rst_dig_en_n", {5'b0, dig_en_n}, 8'h07);
      chk("rst_page", {6'b0, page}, 8'h00);

      pm = 1'b1;
      hh = 8'h12;
      mm = 8'h34;
      ss = 8'h59;
      seg_q.delete();
      page_q.delete();
      m_page = 2'd0;
      lvl_prev = 1'b0;
      push_frame(2'd0, 1'b1, 8'h12, 8'h34, 8'h59);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_frame(1'b0, 8'h12, 8'h34, 8'h59, 0, 1'b0); // 'P','1','2'; next AM
      run_frame(1'b0, 8'h07, 8'h34, 8'h59, 0, 1'b0); // 'A','1','2'
      run_frame(1'b0, 8'h07, 8'h5C, 8'h59, 1, 1'b0); // hours tens zero; one pulse
      run_frame(1'b0, 8'h07, 8'h5C, 8'h59, 0, 1'b1); // minutes with bad ones nibble; hold high
      run_frame(1'b0, 8'h07, 8'h5C, 8'h00, 0, 1'b1); // seconds 59 while ss goes to 00
      run_frame(1'b0, 8'h07, 8'h5C, 8'h00, 0, 1'b1); // still held, no advance
      run_frame(1'b0, 8'h07, 8'h5C, 8'h00, 3, 1'b0); // three pulses: page 2 -> 0
      run_frame(1'b1, 8'h09, 8'h00, 8'h00, 0, 1'b0);
      run_frame(1'b1, 8'h09, 8'h00, 8'h00, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
